// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its ROM interface.
package if_stage_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_data_t;

  localparam inst_addr_t  RESET_VECTOR    = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic        CHIP_ENABLE     = 1'b1;
  localparam logic        CHIP_DISABLE    = 1'b0;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  // Modulo-2^32 sequential PC; low bits pass through untouched.
  function automatic inst_addr_t pc_advance(input inst_addr_t pc, input int unsigned step);
    return pc + inst_addr_t'(step);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// ROM fetch interface: the fetch stage drives enable and address, the ROM returns data the same cycle.
interface i_fetch_inst;
  import if_stage_pkg::*;

  logic       en;
  inst_addr_t addr;
  inst_data_t data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with chip-enable flop and next-PC priority mux; drives the ROM fetch port.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = RESET_VECTOR,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  i_fetch_inst.master       fetch,
  input  logic              stall_pc,
  input  logic              branch_flag,
  input  inst_addr_t        branch_target,
  input  logic              flush,
  input  inst_addr_t        flush_pc
);

  logic       r_en;
  inst_addr_t r_pc;
  inst_addr_t w_pc_next;

  // A branch seen during a PC stall is dropped; ID re-asserts it once released.
  always_comb begin
    w_pc_next = pc_advance(r_pc, PC_STEP);
    if (r_en == CHIP_DISABLE) begin
      w_pc_next = RESET_PC;
    end else if (flush) begin
      w_pc_next = flush_pc;
    end else if (stall_pc) begin
      w_pc_next = r_pc;
    end else if (branch_flag) begin
      w_pc_next = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= CHIP_DISABLE;
      r_pc <= RESET_PC;
    end else begin
      r_en <= CHIP_ENABLE;
      r_pc <= w_pc_next;
    end
  end

  assign fetch.en   = r_en;
  assign fetch.addr = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC/fetch control plus the IF/ID pipeline register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = RESET_VECTOR,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  i_fetch_inst.master inst,
  input  logic        stall_pc,
  input  logic        stall_id,
  input  logic        branch_flag,
  input  inst_addr_t  branch_target,
  input  logic        flush,
  input  inst_addr_t  flush_pc,
  output inst_addr_t  id_pc,
  output inst_data_t  id_inst
);

  inst_addr_t r_id_pc;
  inst_data_t r_id_inst;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch         (inst),
    .stall_pc      (stall_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  // A PC stall with decode free inserts a bubble so the held fetch is not issued twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_pc   <= ZERO_WORD;
      r_id_inst <= ZERO_WORD;
    end else if (inst.en == CHIP_DISABLE || flush || (stall_pc && !stall_id)) begin
      r_id_pc   <= ZERO_WORD;
      r_id_inst <= ZERO_WORD;
    end else if (!stall_id) begin
      r_id_pc   <= inst.addr;
      r_id_inst <= inst.data;
    end
  end

  assign id_pc   = r_id_pc;
  assign id_inst = r_id_inst;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic against a reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_pc, stall_id, branch_flag, flush;
  logic [31:0] branch_target, flush_pc;
  logic [31:0] id_pc, id_inst;

  always #5 clk = ~clk;

  i_fetch_inst inst_bus ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  always_comb inst_bus.data = rom_word(inst_bus.addr);

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst_bus),
    .stall_pc      (stall_pc),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  always @(posedge clk)
    if (rst_n === 1'b1)
      assert (!(stall_id && !stall_pc)) else $error("illegal stall combination stall_id without stall_pc");

  // Reference model: what the fetch stage has fetched and what decode is holding.
  logic        m_en;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},      {31'b0, inst_bus.en}, {31'b0, m_en});
    check({tag, ".addr"},    inst_bus.addr,        m_pc);
    check({tag, ".id_pc"},   id_pc,                m_id_pc);
    check({tag, ".id_inst"}, id_inst,              m_id_inst);
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0;
  endtask

  task automatic tick(input string tag);
    logic [31:0] nx_pc, nx_id_pc, nx_id_inst;
    if (!m_en) begin
      nx_pc = 32'h0; nx_id_pc = 32'h0; nx_id_inst = 32'h0;
    end else begin
      if (flush)            nx_pc = flush_pc;
      else if (stall_pc)    nx_pc = m_pc;
      else if (branch_flag) nx_pc = branch_target;
      else                  nx_pc = m_pc + 32'd4;
      if (flush || (stall_pc && !stall_id)) begin
        nx_id_pc = 32'h0; nx_id_inst = 32'h0;
      end else if (stall_id) begin
        nx_id_pc = m_id_pc; nx_id_inst = m_id_inst;
      end else begin
        nx_id_pc = m_pc; nx_id_inst = rom_word(m_pc);
      end
    end
    @(posedge clk); #1;
    m_en = 1'b1; m_pc = nx_pc; m_id_pc = nx_id_pc; m_id_inst = nx_id_inst;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall_pc = 0; stall_id = 0; branch_flag = 0; flush = 0;
    branch_target = 32'h0; flush_pc = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();

    // 1. reset and startup
    repeat (3) begin
      @(posedge clk); #1;
      check_all("reset");
    end
    rst_n = 1'b1;
    tick("start0");
    check("start.en_one", {31'b0, inst_bus.en}, 32'h1);
    check("start.addr0", inst_bus.addr, 32'h0);
    tick("start1");
    check("start.addr4", inst_bus.addr, 32'h4);
    tick("start2");
    tick("start3");
    check("start.addr12", inst_bus.addr, 32'hC);
    check("start.word2", id_inst, rom_word(32'h8));
    tick("start4");

    // 2. branch with delay slot at 0x10
    check("br.addr10", inst_bus.addr, 32'h10);
    branch_flag = 1; branch_target = 32'h40;
    tick("br0");
    check("br.addr40", inst_bus.addr, 32'h40);
    check("br.slot_pc", id_pc, 32'h10);
    branch_flag = 0;
    tick("br1");
    check("br.addr44", inst_bus.addr, 32'h44);
    check("br.target_pc", id_pc, 32'h40);

    // 3. stall with bubble, then stall with hold
    flush = 1; flush_pc = 32'h20;
    tick("st.redirect");
    flush = 0;
    stall_pc = 1;
    tick("st.bub0");
    check("st.bub0_inst", id_inst, 32'h0);
    tick("st.bub1");
    check("st.hold_pc", inst_bus.addr, 32'h20);
    stall_pc = 0;
    tick("st.resume");
    check("st.resume_idpc", id_pc, 32'h20);
    check("st.resume_addr", inst_bus.addr, 32'h24);
    stall_pc = 1; stall_id = 1;
    tick("st.hold0");
    tick("st.hold1");
    check("st.hold_idpc", id_pc, 32'h20);
    check("st.hold_inst", id_inst, rom_word(32'h20));
    stall_pc = 0; stall_id = 0;
    tick("st.release");

    // 4. flush beats stall and branch
    flush = 1; flush_pc = 32'h180; stall_pc = 1; branch_flag = 1; branch_target = 32'h40;
    tick("fl");
    check("fl.addr", inst_bus.addr, 32'h180);
    check("fl.idpc", id_pc, 32'h0);
    idle_inputs();

    // 5. wrap-around
    flush = 1; flush_pc = 32'hFFFF_FFF8;
    tick("wr0");
    flush = 0;
    tick("wr1");
    check("wr.addrFC", inst_bus.addr, 32'hFFFF_FFFC);
    tick("wr2");
    check("wr.addr0", inst_bus.addr, 32'h0);
    tick("wr3");

    // 6. async reset between edges while a branch is active
    branch_flag = 1; branch_target = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    idle_inputs();
    @(posedge clk); #1;
    check_all("areset.hold");
    rst_n = 1'b1;
    tick("rs0");
    tick("rs1");
    check("rs.addr4", inst_bus.addr, 32'h4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      flush         = ($urandom_range(0, 19) == 0);
      stall_pc      = ($urandom_range(0, 3) == 0);
      stall_id      = stall_pc && $urandom_range(0, 1) == 1;
      branch_flag   = ($urandom_range(0, 4) == 0);
      branch_target = $urandom;
      flush_pc      = $urandom;
      tick("rand");
    end
    idle_inputs();
    tick("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Holds the program counter, drives the ROM fetch interface (enable + address), and registers the returned instruction and its PC into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch redirect (MIPS delay-slot semantics), pipeline stall with bubble insertion, and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on the first enabled cycle after reset; also the PC value while the chip is disabled.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst  i_fetch_inst.master  -  ROM fetch interface: drives en (1) and addr (32); samples data (inst_data_t, 32).
- stall_pc  in  1  hold PC; no new fetch is accepted.
- stall_id  in  1  hold the IF/ID register contents.
- branch_flag  in  1  ID resolved a taken branch/jump this cycle.
- branch_target  in  32  redirect address, valid with branch_flag.
- flush  in  1  exception/eret flush from control.
- flush_pc  in  32  new PC, valid with flush.
- id_pc  out  32  PC of the instruction presented to decode.
- id_inst  out  32  instruction presented to decode.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - inst.en = CHIP_DISABLE; pc = RESET_PC; id_pc = 0; id_inst = 0.
- Enable:
  - inst.en is a flop. It goes CHIP_ENABLE on the first clk edge after rst_n deasserts and stays enabled until the next reset.
- PC update while en is disabled:
  - pc holds RESET_PC; no other PC update occurs.
- PC update while en is enabled, priority highest first:
  1. flush -> pc <= flush_pc.
  2. stall_pc -> pc holds. A branch_flag in the same cycle is ignored; ID is stalled and re-asserts it.
  3. branch_flag -> pc <= branch_target.
  4. otherwise -> pc <= pc + PC_STEP.
- PC arithmetic:
  - 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
  - Low two bits are passed through unmodified. The ROM ignores addr[1:0]; alignment faults belong to the exception unit.
- inst.addr = pc, combinational from the PC register. The ROM returns data in the same cycle.
- Delay slot:
  - When branch_flag is asserted, the instruction currently being fetched (at pc) is the delay slot.
  - It enters IF/ID normally on that edge; the target is fetched on the next cycle.
- IF/ID register, priority highest first:
  1. flush -> id_pc <= 0, id_inst <= 0 (bubble).
  2. stall_pc && !stall_id -> bubble (id_pc <= 0, id_inst <= 0).
  3. stall_id -> hold.
  4. otherwise -> id_pc <= pc, id_inst <= inst.data.
  - While en is disabled, the register loads zeros.
- Latency:
  - The instruction at address A appears on id_inst exactly one cycle after pc == A with no stall.
  - Throughput is one instruction per cycle.
- Stall consistency:
  - stall_id && !stall_pc is illegal; the controller never produces it.
  - Verification asserts its absence; RTL behaviour in that case is "PC advances, IF/ID holds".
- Reset mid-operation:
  - Asynchronous return to reset values regardless of stall, branch or flush.
  - After release, fetch restarts at RESET_PC.

Decomposition:
- project_types (shared package) gains:
  - inst_addr_t (32-bit logic);
  - RESET_VECTOR constant (default for RESET_PC);
  - ZERO_WORD constant.
  - It reuses inst_data_t and CHIP_ENABLE/CHIP_DISABLE.
- One natural sub-module: pc_reg.
  - Contains: enable flop, PC register, next-PC priority mux.
  - Drives inst.en and inst.addr.
- The IF/ID register stays in if_stage top.

Test Plan:
1. Reset/startup: hold rst_n low 3 cycles, release. Required:
   - en = 0 during reset, 1 one edge after release;
   - addr sequence 0, 4, 8, 12;
   - id_inst = ROM words 0..3, each one cycle after its address.
2. Branch with delay slot: at pc = 0x10, assert branch_flag with target 0x40 for one cycle. Required:
   - addr sequence 0x10, 0x40, 0x44;
   - id_pc sequence 0x10 (delay slot), then 0x40.
3. Stall with bubble: stall_pc = 1, stall_id = 0 for 2 cycles at pc = 0x20. Required:
   - pc holds 0x20;
   - id_inst = 0 for 2 cycles;
   - then id_pc = 0x20 and fetch resumes at 0x24.
   - Repeat with stall_id = 1: IF/ID holds the previous instruction.
4. Flush precedence: assert flush (flush_pc = 0x180) together with stall_pc and branch_flag (target 0x40). Required:
   - next addr = 0x180;
   - id_pc = 0 and id_inst = 0 on that edge.
5. Wrap-around: flush_pc = 0xFFFF_FFF8, then run 3 cycles. Required:
   - addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Async reset mid-stream: drop rst_n between edges while branch_flag is active. Required:
   - en = 0, id_pc = 0 and id_inst = 0 immediately, without waiting for a clock edge;
   - restart at RESET_PC after release.
